// File: rtl/sample_iterator_if.sv
// sample_iterator_if
//   Bundles the triangle/box input side and the sample output side of the
//   sample iterator.
//   master : the triangle/box producer and sample consumer. It drives the
//            R13 inputs and observes halt and the R14 outputs.
//   slave  : the sample_iterator itself.
//   Signals:
//     tri_R13S / color_R13U / box_R13S / validTri_R13H : triangle + box in
//     subSample_RnnnnU : one-hot MSAA mode
//     halt_RnnnnL      : low while iterating (upstream must hold)
//     tri_R14S / color_R14U / sample_R14S / validSamp_R14H : sample out
interface sample_iterator_if #(
   parameter int SIGFIG = 24,
   parameter int VERTS  = 3,
   parameter int AXIS   = 3,
   parameter int COLORS = 3
);
   logic signed [SIGFIG-1:0] tri_R13S    [VERTS][AXIS];
   logic        [SIGFIG-1:0] color_R13U  [COLORS];
   logic signed [SIGFIG-1:0] box_R13S    [2][2];
   logic                     validTri_R13H;
   logic        [3:0]        subSample_RnnnnU;
   logic                     halt_RnnnnL;
   logic signed [SIGFIG-1:0] tri_R14S    [VERTS][AXIS];
   logic        [SIGFIG-1:0] color_R14U  [COLORS];
   logic signed [SIGFIG-1:0] sample_R14S [2];
   logic                     validSamp_R14H;

   modport master (
      output tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU,
      input  halt_RnnnnL, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
   );

   modport slave (
      input  tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU,
      output halt_RnnnnL, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
   );
endinterface

// File: rtl/sample_iterator.sv
// sample_iterator
//   Accepts one triangle with its pixel-snapped bounding box and walks every
//   subsample position in the box in raster order, one sample per cycle.
//   Ports:
//     clk  : clock
//     rst  : asynchronous active-low reset
//     bus  : sample_iterator_if.slave (triangle/box in, sample out, halt)
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   WAIT  | idle, halt high, accepting a triangle with a non-empty box
//   TEST  | iterating; sample_R14S valid every cycle, upstream held
module sample_iterator #(
   parameter int SIGFIG = 24,
   parameter int RADIX  = 10,
   parameter int VERTS  = 3,
   parameter int AXIS   = 3,
   parameter int COLORS = 3
) (
   input logic             clk,
   input logic             rst,
   sample_iterator_if.slave bus
);

   typedef enum logic {
      WAIT = 1'b0,
      TEST = 1'b1
   } state_t;

   state_t                   state;
   logic signed [SIGFIG-1:0] tri_q   [VERTS][AXIS];
   logic        [SIGFIG-1:0] color_q [COLORS];
   logic signed [SIGFIG-1:0] ll_x, ll_y, ur_x, ur_y;
   logic signed [SIGFIG-1:0] samp_x, samp_y;
   logic        [SIGFIG-1:0] step_q;
   logic                     valid_q;

   logic        [SIGFIG-1:0] step_sel;
   logic                     box_ok;
   logic signed [SIGFIG:0]   next_x, next_y, ur_xw, ur_yw;
   logic                     x_fits, y_fits;

   // Anything that is not a clean one-hot code falls back to 1 sample/pixel.
   always_comb begin
      step_sel = SIGFIG'(1) << RADIX;
      case (bus.subSample_RnnnnU)
         4'b0100: step_sel = SIGFIG'(1) << (RADIX - 1);
         4'b0010: step_sel = SIGFIG'(1) << (RADIX - 2);
         4'b0001: step_sel = SIGFIG'(1) << (RADIX - 3);
         default: step_sel = SIGFIG'(1) << RADIX;
      endcase
   end

   assign box_ok = (bus.box_R13S[1][0] >= bus.box_R13S[0][0]) &&
                   (bus.box_R13S[1][1] >= bus.box_R13S[0][1]);

   // One extra bit so a step past the top of the signed range cannot wrap
   // around and compare as less than the upper-right corner.
   assign next_x = {samp_x[SIGFIG-1], samp_x} + {1'b0, step_q};
   assign next_y = {samp_y[SIGFIG-1], samp_y} + {1'b0, step_q};
   assign ur_xw  = {ur_x[SIGFIG-1], ur_x};
   assign ur_yw  = {ur_y[SIGFIG-1], ur_y};
   assign x_fits = (next_x <= ur_xw);
   assign y_fits = (next_y <= ur_yw);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= WAIT;
         valid_q <= 1'b0;
         samp_x  <= '0;
         samp_y  <= '0;
         ll_x    <= '0;
         ll_y    <= '0;
         ur_x    <= '0;
         ur_y    <= '0;
         step_q  <= '0;
         for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
               tri_q[v][a] <= '0;
         for (int c = 0; c < COLORS; c++)
            color_q[c] <= '0;
      end else begin
         case (state)
            WAIT: begin
               if (bus.validTri_R13H && box_ok) begin
                  tri_q   <= bus.tri_R13S;
                  color_q <= bus.color_R13U;
                  ll_x    <= bus.box_R13S[0][0];
                  ll_y    <= bus.box_R13S[0][1];
                  ur_x    <= bus.box_R13S[1][0];
                  ur_y    <= bus.box_R13S[1][1];
                  samp_x  <= bus.box_R13S[0][0];
                  samp_y  <= bus.box_R13S[0][1];
                  step_q  <= step_sel;
                  valid_q <= 1'b1;
                  state   <= TEST;
               end else begin
                  valid_q <= 1'b0;
               end
            end
            TEST: begin
               if (x_fits) begin
                  samp_x <= next_x[SIGFIG-1:0];
               end else if (y_fits) begin
                  samp_x <= ll_x;
                  samp_y <= next_y[SIGFIG-1:0];
               end else begin
                  valid_q <= 1'b0;
                  state   <= WAIT;
               end
            end
            default: begin
               valid_q <= 1'b0;
               state   <= WAIT;
            end
         endcase
      end
   end

   assign bus.halt_RnnnnL    = (state == WAIT);
   assign bus.validSamp_R14H = valid_q;
   assign bus.sample_R14S[0] = samp_x;
   assign bus.sample_R14S[1] = samp_y;
   assign bus.tri_R14S       = tri_q;
   assign bus.color_R14U     = color_q;

endmodule

// File: tb/tb_sample_iterator.sv
// tb_sample_iterator
//   Directed stimulus for sample_iterator. Each triangle pushes its expected
//   samples (position, triangle tag, output cycle) into a scoreboard queue;
//   a monitor on the falling edge compares validSamp, halt and sample data.
module tb_sample_iterator;
   localparam int SIGFIG = 24;
   localparam int RADIX  = 10;
   localparam int VERTS  = 3;
   localparam int AXIS   = 3;
   localparam int COLORS = 3;

   logic clk;
   logic rst;
   int   cyc;
   int   checks;
   int   errors;

   sample_iterator_if #(.SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)) bus ();

   sample_iterator #(
      .SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      int x;
      int y;
      int tag;
      int cyc;
   } exp_t;

   exp_t q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic bit data_ok(int tag);
      bit ok;
      ok = 1'b1;
      for (int v = 0; v < VERTS; v++)
         for (int a = 0; a < AXIS; a++)
            if (bus.tri_R14S[v][a] !== SIGFIG'(tag * 16 + v * 3 + a)) ok = 1'b0;
      for (int c = 0; c < COLORS; c++)
         if (bus.color_R14U[c] !== SIGFIG'(tag * 16 + 10 + c)) ok = 1'b0;
      return ok;
   endfunction

   // Scoreboard monitor
   always @(negedge clk) begin
      bit exp_v;
      if (rst) begin
         while (q.size() > 0 && q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_sample: sample (%0d,%0d) expected at cycle %0d never seen, now cycle %0d",
                     q[0].x, q[0].y, q[0].cyc, cyc);
            void'(q.pop_front());
         end
         exp_v = (q.size() > 0) && (q[0].cyc == cyc);
         checks++;
         if (bus.validSamp_R14H !== exp_v) begin
            errors++;
            $display("FAIL valid: cycle %0d validSamp=%b required %b", cyc, bus.validSamp_R14H, exp_v);
         end
         checks++;
         if (bus.halt_RnnnnL !== !exp_v) begin
            errors++;
            $display("FAIL halt: cycle %0d halt=%b required %b", cyc, bus.halt_RnnnnL, !exp_v);
         end
         if (exp_v) begin
            if (bus.validSamp_R14H === 1'b1) begin
               checks++;
               if (int'(bus.sample_R14S[0]) != q[0].x || int'(bus.sample_R14S[1]) != q[0].y) begin
                  errors++;
                  $display("FAIL sample_pos: cycle %0d got (%0d,%0d) required (%0d,%0d)", cyc,
                           int'(bus.sample_R14S[0]), int'(bus.sample_R14S[1]), q[0].x, q[0].y);
               end
               checks++;
               if (!data_ok(q[0].tag)) begin
                  errors++;
                  $display("FAIL tri_color: cycle %0d tri[0][0]=%0d color[0]=%0d required tag %0d (tri %0d color %0d)",
                           cyc, bus.tri_R14S[0][0], bus.color_R14U[0], q[0].tag,
                           q[0].tag * 16, q[0].tag * 16 + 10);
               end
            end
            void'(q.pop_front());
         end
      end
   end

   // Present a triangle; returns on the falling edge after it was accepted
   // (halt high at the edge). Expected samples are pushed just before that
   // accepting edge: the first appears the cycle after, then one per cycle.
   task automatic send(input int llx, input int lly, input int urx, input int ury,
                       input int tag, input logic [3:0] ss, input int step, input bit hold);
      bit acc;
      int k;
      int n;
      for (int v = 0; v < VERTS; v++)
         for (int a = 0; a < AXIS; a++)
            bus.tri_R13S[v][a] = SIGFIG'(tag * 16 + v * 3 + a);
      for (int c = 0; c < COLORS; c++)
         bus.color_R13U[c] = SIGFIG'(tag * 16 + 10 + c);
      bus.box_R13S[0][0]    = SIGFIG'(llx);
      bus.box_R13S[0][1]    = SIGFIG'(lly);
      bus.box_R13S[1][0]    = SIGFIG'(urx);
      bus.box_R13S[1][1]    = SIGFIG'(ury);
      bus.subSample_RnnnnU  = ss;
      bus.validTri_R13H     = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 200 && !acc; t++) begin
         if (bus.halt_RnnnnL === 1'b1) begin
            acc = 1'b1;
            k   = cyc + 1;
            n   = 0;
            for (int y = lly; y <= ury; y += step)
               for (int x = llx; x <= urx; x += step) begin
                  q.push_back('{x: x, y: y, tag: tag, cyc: k + n});
                  n++;
               end
         end
         @(posedge clk);
         @(negedge clk);
      end
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: triangle tag %0d not accepted, halt=%b required 1", tag, bus.halt_RnnnnL);
      end
      if (!hold) bus.validTri_R13H = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int t = 0; t < 300 && q.size() > 0; t++) @(negedge clk);
      if (q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain_%s: %0d samples outstanding, required 0", name, q.size());
         q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic check_zero(input string name);
      bit z;
      z = data_ok(0) === 1'b0 ? 1'b0 : 1'b1;
      // data_ok(0) expects tag-0 patterns, so check all-zero explicitly
      z = 1'b1;
      for (int v = 0; v < VERTS; v++)
         for (int a = 0; a < AXIS; a++)
            if (bus.tri_R14S[v][a] !== '0) z = 1'b0;
      for (int c = 0; c < COLORS; c++)
         if (bus.color_R14U[c] !== '0) z = 1'b0;
      if (bus.sample_R14S[0] !== '0 || bus.sample_R14S[1] !== '0) z = 1'b0;
      checks++;
      if (!z || bus.validSamp_R14H !== 1'b0 || bus.halt_RnnnnL !== 1'b1) begin
         errors++;
         $display("FAIL %s: valid=%b halt=%b sample=(%0d,%0d) tri00=%0d color0=%0d required valid=0 halt=1 all zero",
                  name, bus.validSamp_R14H, bus.halt_RnnnnL, bus.sample_R14S[0], bus.sample_R14S[1],
                  bus.tri_R14S[0][0], bus.color_R14U[0]);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b0;
      bus.validTri_R13H    = 1'b0;
      bus.subSample_RnnnnU = 4'b1000;
      for (int v = 0; v < VERTS; v++)
         for (int a = 0; a < AXIS; a++)
            bus.tri_R13S[v][a] = '0;
      for (int c = 0; c < COLORS; c++)
         bus.color_R13U[c] = '0;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++)
            bus.box_R13S[i][j] = '0;
      repeat (3) @(negedge clk);
      check_zero("reset_state");
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // 1spp: (0,0),(1024,0),(0,1024),(1024,1024)
      send(0, 0, 1024, 1024, 1, 4'b1000, 1024, 1'b0);
      drain("1spp");

      // 4spp, step 512: x 0,512,1024 at y 0 then y 512
      send(0, 0, 1024, 512, 2, 4'b0100, 512, 1'b0);
      drain("4spp");

      // Degenerate box: single sample (2048,3072)
      send(2048, 3072, 2048, 3072, 3, 4'b1000, 1024, 1'b0);
      drain("degenerate");

      // Empty box: nothing emitted, halt stays high
      send(1024, 0, 0, 0, 4, 4'b1000, 1024, 1'b0);
      repeat (4) @(negedge clk);
      drain("empty");

      // validTri held: one-pixel boxes back to back, one bubble between
      send(0, 0, 0, 0, 6, 4'b1000, 1024, 1'b1);
      send(1024, 1024, 1024, 1024, 7, 4'b1000, 1024, 1'b0);
      drain("back_to_back");

      // Reset during 3rd sample of a 16-sample triangle (step 256, 4x4)
      send(0, 0, 768, 768, 5, 4'b0010, 256, 1'b0);
      @(negedge clk);
      @(negedge clk);
      #1 rst = 1'b0;
      #1 check_zero("async_reset_abort");
      q.delete();
      @(negedge clk);
      check_zero("reset_hold");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      send(256, 512, 512, 512, 8, 4'b0010, 256, 1'b0);
      drain("after_reset");

      // subSample changes mid-triangle are ignored: step stays 1024
      send(0, 0, 2048, 0, 9, 4'b1000, 1024, 1'b0);
      bus.subSample_RnnnnU = 4'b0001;
      drain("ss_toggle");
      // Next triangle uses step 128: x 0,128,256 at y 0 then 128
      send(0, 0, 256, 128, 10, 4'b0001, 128, 1'b0);
      drain("64spp");

      // Non-one-hot subSample treated as 1spp
      send(0, 0, 1024, 0, 11, 4'b0011, 1024, 1'b0);
      drain("non_onehot");

      // Negative coordinates compare signed
      send(-1024, -1024, 0, -1024, 12, 4'b1000, 1024, 1'b0);
      drain("negative");

      // Top of signed range: x+step would wrap in 24 bits; one sample only
      send(8387584, 0, 8387584, 0, 13, 4'b1000, 1024, 1'b0);
      drain("wrap_edge");

      // Off-grid UR: stops at last grid point <= UR -> x 0,1024 only
      send(0, 0, 1500, 0, 14, 4'b1000, 1024, 1'b0);
      drain("off_grid");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/sample_iterator.md
Name: sample_iterator

Overview:
- Raster stage between bounding-box generation and sample test.
- Accepts one triangle plus its pixel-snapped bounding box, then walks every subsample position in the box in raster order, one per cycle.
- Emits sample location, triangle and colour to the sample test stage.
- Back-pressures the bounding-box stage with an active-low halt while iterating.

Parameters:
- SIGFIG, 24, bits in colour and position.
- RADIX, 10, fraction bits in colour and position.
- VERTS, 3, vertices per triangle.
- AXIS, 3, axes per vertex (x,y,z).
- COLORS, 3, colour channels.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- tri_R13S  in  signed SIGFIG x [VERTS][AXIS]  triangle.
- color_R13U  in  unsigned SIGFIG x [COLORS]  triangle colour.
- box_R13S  in  signed SIGFIG x [2][2]  bounding box; [0]=lower-left, [1]=upper-right; [*][0]=x, [*][1]=y.
- validTri_R13H  in  1  triangle/box valid.
- subSample_RnnnnU  in  4  one-hot MSAA mode: 4'b1000=1, 4'b0100=4, 4'b0010=16, 4'b0001=64 samples/pixel.
- halt_RnnnnL  out  1  low = upstream must hold its outputs.
- tri_R14S  out  signed SIGFIG x [VERTS][AXIS]  latched triangle.
- color_R14U  out  unsigned SIGFIG x [COLORS]  latched colour.
- sample_R14S  out  signed SIGFIG x [2]  current sample (x,y).
- validSamp_R14H  out  1  sample_R14S valid.

Behaviour:
- Reset (rst low, async): state=WAIT; validSamp_R14H=0; sample_R14S, tri_R14S, color_R14U all 0; halt_RnnnnL=1.
- halt_RnnnnL = (state==WAIT); purely a decode of registered state.
- Step: 1<<RADIX, RADIX-1, RADIX-2, RADIX-3 for subSample 1000/0100/0010/0001. Step is latched at triangle accept; mid-triangle subSample changes are ignored. Non-one-hot subSample is treated as 1000.

WAIT state:
- Rising edge with validTri_R13H=1 and a non-empty box (urx>=llx and ury>=lly): latch tri, colour and box; sample_R14S<=LL; validSamp_R14H<=1; state<=TEST.
- validTri with an empty box: nothing latched, no samples, stay WAIT.
- validTri=0: validSamp_R14H<=0.

TEST state, each edge:
- If x+step<=urx: x<=x+step.
- Else if y+step<=ury: x<=llx, y<=y+step.
- Else (last sample was on output): validSamp_R14H<=0, state<=WAIT.
- validTri_R13H is ignored in TEST.

Timing and arithmetic:
- Latency: first sample appears the cycle after accept; N samples take N consecutive valid cycles.
- halt rises the cycle after the last sample; the next triangle is accepted on that cycle's edge. This gives exactly one bubble between triangles.
- Comparisons are signed, SIGFIG wide. The x+step and y+step sums are computed one bit wider so wrap-around never compares incorrectly.
- Upstream guarantees LL and UR lie on the step grid. If they do not, iteration stops at the last grid point <= UR.
- A degenerate box (LL==UR) produces exactly one sample, then WAIT.
- tri_R14S and color_R14U stay constant for all samples of a triangle.
- Reset mid-iteration aborts immediately; no further samples are emitted.

Test Plan:
- 1spp, box LL(0,0) UR(1024,1024), validTri one cycle -> samples (0,0),(1024,0),(0,1024),(1024,1024) on 4 consecutive cycles; halt low for those 4 cycles, high the next.
- 4spp, box LL(0,0) UR(1024,512) -> step 512; 6 samples: x 0,512,1024 at y 0 then y 512; tri/colour unchanged on every sample.
- Degenerate box LL=UR=(2048,3072) -> single sample (2048,3072), validSamp high 1 cycle; empty box LL(1024,0) UR(0,0) -> no validSamp, halt stays 1.
- validTri held high with two back-to-back 1spp 1-pixel boxes (0,0) then (1024,1024) -> valid samples on cycles 1 and 3, bubble on cycle 2; second triangle data latched correctly.
- rst asserted during the 3rd sample of a 16-sample triangle -> outputs zero asynchronously, halt=1; after release, a new triangle iterates from its LL.
- subSample toggled 1000->0001 mid-triangle -> step stays 1024 until WAIT; next triangle uses step 128.
